// File: rtl/spi_slave_bytes.sv
// spi_slave_bytes: byte-level SPI mode 0 slave (MSB first) for the MiST ARM link.
// The SPI pins are oversampled in the clk domain. Received bytes are handed to
// fabric logic, and reply bytes are shifted back out through a one-entry
// holding register.
module spi_slave_bytes #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         COUNT_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  spi_ss_n,
  input  logic                  spi_di,
  output logic                  spi_do,
  output logic                  spi_do_oe,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  rx_first,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  selected,
  output logic [COUNT_BITS-1:0] byte_count,
  output logic                  underrun,
  output logic                  abort
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t                  state_r, next_state_s;
  logic [SYNC_STAGES-1:0]  sck_sync_r, ss_sync_r, di_sync_r;
  logic                    sck_d_r, ss_d_r;
  logic                    sck_s, ss_s, di_s;
  logic                    sck_rise_s, sck_fall_s, sel_on_s, sel_off_s;
  logic                    start_s, stop_s, load_tx_s, shift_tx_s, shift_rx_s;
  logic [2:0]              bit_cnt_r, bit_cnt_next_s;
  logic                    abort_s, byte_done_s;
  logic [6:0]              rx_shift_r, tx_shift_r;
  logic [7:0]              rx_byte_s, load_byte_s, hold_r;
  logic                    first_r;
  logic                    spi_do_r, spi_do_oe_r, rx_valid_r, rx_first_r;
  logic                    tx_ready_r, selected_r, underrun_r, abort_r;
  logic [7:0]              rx_data_r;
  logic [COUNT_BITS-1:0]   byte_count_r;

  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign ss_s       = ss_sync_r[SYNC_STAGES-1];
  assign di_s       = di_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_d_r;
  assign sck_fall_s = ~sck_s & sck_d_r;
  assign sel_on_s   = ~ss_s & ss_d_r;
  assign sel_off_s  = ss_s & ~ss_d_r;

  // An empty holding register at a reload means the idle byte goes out.
  assign load_byte_s    = tx_ready_r ? IDLE_BYTE : hold_r;
  assign rx_byte_s      = {rx_shift_r, di_s};
  assign bit_cnt_next_s = shift_rx_s ? (bit_cnt_r + 3'd1) : bit_cnt_r;
  assign byte_done_s    = shift_rx_s && (bit_cnt_r == 3'd7);
  // A deselect that lands on the eighth rising edge completes the byte cleanly.
  assign abort_s        = stop_s && (bit_cnt_next_s != 3'd0);

  // Synchronise the three SPI pins through matched chains and keep one extra copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_r <= {SYNC_STAGES{1'b0}};
      ss_sync_r  <= {SYNC_STAGES{1'b1}};
      di_sync_r  <= {SYNC_STAGES{1'b0}};
      sck_d_r    <= 1'b0;
      ss_d_r     <= 1'b1;
    end else begin
      sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], spi_sck};
      ss_sync_r  <= {ss_sync_r[SYNC_STAGES-2:0], spi_ss_n};
      di_sync_r  <= {di_sync_r[SYNC_STAGES-2:0], spi_di};
      sck_d_r    <= sck_s;
      ss_d_r     <= ss_s;
    end
  end

  // Hold the transfer state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Decode select and SCK edges into the datapath actions for this cycle.
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    stop_s       = 1'b0;
    load_tx_s    = 1'b0;
    shift_tx_s   = 1'b0;
    shift_rx_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_on_s) begin
          next_state_s = ST_SHIFT;
          start_s      = 1'b1;
          load_tx_s    = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sck_rise_s) begin
          shift_rx_s = 1'b1;
        end else begin
          shift_rx_s = 1'b0;
        end
        if (sel_off_s) begin
          next_state_s = ST_IDLE;
          stop_s       = 1'b1;
        end else if (sck_fall_s) begin
          if (bit_cnt_r != 3'd0) begin
            shift_tx_s = 1'b1;
          end else begin
            load_tx_s  = 1'b1;
          end
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: shifters, holding register, byte counting and the registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_do_r     <= 1'b1;
      spi_do_oe_r  <= 1'b0;
      rx_data_r    <= 8'h00;
      rx_valid_r   <= 1'b0;
      rx_first_r   <= 1'b0;
      tx_ready_r   <= 1'b1;
      selected_r   <= 1'b0;
      byte_count_r <= {COUNT_BITS{1'b0}};
      underrun_r   <= 1'b0;
      abort_r      <= 1'b0;
      hold_r       <= 8'h00;
      rx_shift_r   <= 7'h00;
      tx_shift_r   <= 7'h00;
      bit_cnt_r    <= 3'd0;
      first_r      <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      rx_first_r <= 1'b0;
      underrun_r <= 1'b0;
      abort_r    <= 1'b0;

      if (start_s) begin
        selected_r   <= 1'b1;
        spi_do_oe_r  <= 1'b1;
        byte_count_r <= {COUNT_BITS{1'b0}};
        bit_cnt_r    <= 3'd0;
        first_r      <= 1'b1;
      end

      // Bit 7 goes straight to the pin; the shifter keeps the remaining seven.
      if (load_tx_s) begin
        spi_do_r   <= load_byte_s[7];
        tx_shift_r <= load_byte_s[6:0];
        if (tx_ready_r) begin
          underrun_r <= 1'b1;
        end else begin
          tx_ready_r <= 1'b1;
        end
      end else if (shift_tx_s) begin
        spi_do_r   <= tx_shift_r[6];
        tx_shift_r <= {tx_shift_r[5:0], 1'b0};
      end

      // Acceptance sees the pre-reload tx_ready, so a byte taken during a reload waits for the next boundary.
      if (tx_valid && tx_ready_r) begin
        hold_r     <= tx_data;
        tx_ready_r <= 1'b0;
      end

      if (shift_rx_s) begin
        rx_shift_r <= rx_byte_s[6:0];
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        if (byte_done_s) begin
          rx_data_r  <= rx_byte_s;
          rx_valid_r <= 1'b1;
          rx_first_r <= first_r;
          first_r    <= 1'b0;
          if (byte_count_r != {COUNT_BITS{1'b1}}) begin
            byte_count_r <= byte_count_r + {{(COUNT_BITS-1){1'b0}}, 1'b1};
          end
        end
      end

      if (stop_s) begin
        selected_r  <= 1'b0;
        spi_do_oe_r <= 1'b0;
        spi_do_r    <= 1'b1;
        bit_cnt_r   <= 3'd0;
        rx_shift_r  <= 7'h00;
        abort_r     <= abort_s;
      end
    end
  end

  assign spi_do     = spi_do_r;
  assign spi_do_oe  = spi_do_oe_r;
  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign rx_first   = rx_first_r;
  assign tx_ready   = tx_ready_r;
  assign selected   = selected_r;
  assign byte_count = byte_count_r;
  assign underrun   = underrun_r;
  assign abort      = abort_r;

endmodule

// File: tb/tb_spi_slave_bytes.sv
// tb_spi_slave_bytes: directed and randomised SPI mode 0 transfers at clk/8.
// The expected replies and received bytes come from a transfer-level model.
module tb_spi_slave_bytes;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset, spi_sck, spi_ss_n, spi_di;
  logic       spi_do, spi_do_oe, rx_valid, rx_first, tx_valid, tx_ready;
  logic       selected, underrun, abort;
  logic [7:0] rx_data, tx_data, byte_count;

  spi_slave_bytes #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF), .COUNT_BITS(8)) dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_ss_n(spi_ss_n),
    .spi_di(spi_di), .spi_do(spi_do), .spi_do_oe(spi_do_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .selected(selected), .byte_count(byte_count), .underrun(underrun),
    .abort(abort)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0, fails = 0;
  int und_cnt = 0, abort_cnt = 0, und_snap = 0, falls = 0;
  logic [7:0] rx_q[$];
  logic       rf_q[$];
  logic [7:0] mosi_b[4];
  logic [7:0] miso_b[4];
  logic [7:0] exp_miso[4];

  // Record pulse outputs shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rx_valid === 1'b1) begin
      rx_q.push_back(rx_data);
      rf_q.push_back(rx_first);
    end
    if (underrun === 1'b1) und_cnt++;
    if (abort === 1'b1) abort_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    rf_q.delete();
    und_cnt   = 0;
    abort_cnt = 0;
    falls     = 0;
    und_snap  = 0;
  endtask

  // Offer one reply byte and hold tx_valid until it is taken (bounded).
  task automatic offer(input logic [7:0] v);
    logic ok, rdy;
    ok = 1'b0;
    tx_data  = v;
    tx_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      rdy = tx_ready;
      @(negedge clk);
      if (rdy === 1'b1) ok = 1'b1;
    end
    tx_valid = 1'b0;
    chk($sformatf("offer_%02h", v), 32'(ok), 32'd1);
  endtask

  // Clock nbits of v out MSB first, sampling miso just before each rising edge.
  task automatic send_bits(input logic [7:0] v, input int nbits, input bit snap, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_di = v[7-i];
      repeat (4) @(negedge clk);
      got[7-i] = spi_do;
      spi_sck  = 1'b1;
      repeat (4) @(negedge clk);
      if (snap && i == nbits - 1) und_snap = und_cnt;
      spi_sck = 1'b0;
      falls++;
    end
  endtask

  task automatic xfer(input int n);
    logic [7:0] got;
    spi_ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < n; b++) begin
      send_bits(mosi_b[b], 8, (b == n - 1), got);
      miso_b[b] = got;
    end
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Underruns are counted from select up to the last byte's final falling edge.
  task automatic check_xfer(input string tag, input int n, input int exp_und);
    logic [31:0] obs;
    chk({tag, "_nrx"}, 32'(rx_q.size()), 32'(n));
    for (int b = 0; b < n; b++) begin
      obs = (b < rx_q.size()) ? 32'(rx_q[b]) : 32'hDEAD;
      chk($sformatf("%s_rx%0d", tag, b), obs, 32'(mosi_b[b]));
      obs = (b < rf_q.size()) ? 32'(rf_q[b]) : 32'hDEAD;
      chk($sformatf("%s_first%0d", tag, b), obs, (b == 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s_miso%0d", tag, b), 32'(miso_b[b]), 32'(exp_miso[b]));
    end
    chk({tag, "_underrun"}, 32'(und_snap), 32'(exp_und));
    chk({tag, "_count"}, 32'(byte_count), 32'(n));
    chk({tag, "_abort"}, 32'(abort_cnt), 32'd0);
    chk({tag, "_idle"}, 32'({spi_do_oe, selected}), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_outs"}, 32'({spi_do, spi_do_oe, rx_valid, rx_first, tx_ready, selected, underrun, abort}),
        32'(8'b1000_1000));
    chk({tag, "_rxdata"}, 32'(rx_data), 32'd0);
    chk({tag, "_count"}, 32'(byte_count), 32'd0);
  endtask

  initial begin
    logic [7:0] tmp, qb;
    logic       seen;
    int         n, q;
    reset = 1'b1; spi_sck = 1'b0; spi_ss_n = 1'b1; spi_di = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    clear_mon();

    // Reset state and a quiet idle period.
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_quiet", 32'({spi_do_oe, tx_ready, rx_valid, underrun, abort, selected}), 32'(6'b010000));
    end

    // Single byte with a queued reply.
    clear_mon();
    offer(8'hA5);
    mosi_b[0] = 8'h3C; exp_miso[0] = 8'hA5;
    xfer(1);
    check_xfer("one", 1, 0);

    // Three bytes with only one reply queued.
    clear_mon();
    offer(8'h55);
    mosi_b[0] = 8'h01; mosi_b[1] = 8'h02; mosi_b[2] = 8'h03;
    exp_miso[0] = 8'h55; exp_miso[1] = 8'hFF; exp_miso[2] = 8'hFF;
    xfer(3);
    check_xfer("three", 3, 2);

    // Deselect after five bits: abort, no byte, output released quickly.
    clear_mon();
    spi_ss_n = 1'b0;
    repeat (8) @(negedge clk);
    send_bits(8'hF0, 5, 1'b0, tmp);
    repeat (2) @(negedge clk);
    spi_ss_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < SYNC + 2 && !seen; i++) begin
      @(negedge clk);
      if (spi_do_oe === 1'b0) seen = 1'b1;
    end
    chk("abort_oe_off", 32'(seen), 32'd1);
    repeat (10) @(negedge clk);
    chk("abort_pulse", 32'(abort_cnt), 32'd1);
    chk("abort_norx", 32'(rx_q.size()), 32'd0);
    clear_mon();
    mosi_b[0] = 8'h81; exp_miso[0] = 8'hFF;
    xfer(1);
    check_xfer("after_abort", 1, 1);

    // A new offer at a boundary reload while a byte is held goes out one byte later.
    clear_mon();
    offer(8'h9C);
    mosi_b[0] = 8'h12; mosi_b[1] = 8'h34; mosi_b[2] = 8'h56;
    exp_miso[0] = 8'h9C; exp_miso[1] = 8'h22; exp_miso[2] = 8'h11;
    fork
      xfer(3);
      begin
        wait (falls >= 1);
        offer(8'h22);
        wait (falls >= 8);
        offer(8'h11);
      end
    join
    check_xfer("boundary", 3, 0);

    // Reset in the middle of a byte.
    clear_mon();
    spi_ss_n = 1'b0;
    repeat (8) @(negedge clk);
    send_bits(8'h5A, 3, 1'b0, tmp);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    spi_ss_n = 1'b1;
    spi_sck  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    clear_mon();
    mosi_b[0] = 8'h7E; exp_miso[0] = 8'hFF;
    xfer(1);
    check_xfer("post_reset", 1, 1);

    // Randomised transfers: first reply is the queued byte or the idle byte, the rest idle.
    for (int t = 0; t < 6; t++) begin
      clear_mon();
      n  = int'($urandom_range(4, 1));
      q  = int'($urandom_range(1, 0));
      qb = 8'($urandom);
      if (q == 1) offer(qb);
      for (int b = 0; b < n; b++) begin
        mosi_b[b]   = 8'($urandom);
        exp_miso[b] = 8'hFF;
      end
      if (q == 1) exp_miso[0] = qb;
      xfer(n);
      check_xfer($sformatf("rand%0d", t), n, n - q);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
